// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory master, the slave-side memory and benches.
package spi_mem_pkg;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = DEF_ADDR_W + 1 + DEF_DATA_W;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_mem_master_sclk_gen.sv
// Half-period counter and SCLK register. While enabled the counter wraps every
// CLK_DIV cycles; when tgl is also set, sclk toggles on each wrap and the
// matching rise/fall strobe is raised in the cycle before the new level appears.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic tgl,
  output logic tc,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV - 1);

  logic [HC_W-1:0] hc;
  logic            sclk_q;

  assign tc   = (hc == HC_MAX);
  assign rise = en && tgl && tc && !sclk_q;
  assign fall = en && tgl && tc && sclk_q;
  assign sclk = sclk_q;

  // Half-period counter: held at zero while idle, wraps on tc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
    end else if (!en || tc) begin
      hc <= '0;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // SCLK level follows the rise/fall strobes; idles low (mode 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b0;
    end else if (rise) begin
      sclk_q <= 1'b1;
    end else if (fall) begin
      sclk_q <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// SPI master for single-byte memory frames {addr, rw, data}, MSB first, mode 0.
// mosi is the MSB of the frame shift register; the register shifts on every
// sclk fall, so mosi only moves on falling edges and drains to zero at the end.
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int FW   = ADDR_W + 1 + DATA_W;
  localparam int BC_W = $clog2(FW);
  localparam logic [BC_W-1:0] BC_TOP  = BC_W'(FW - 1);
  localparam logic [BC_W-1:0] BC_DATA = BC_W'(DATA_W);

  state_t            state, state_next;
  logic [FW-1:0]     sr;
  logic [BC_W-1:0]   bc;
  logic              rw_q;
  logic [DATA_W-1:0] rx;
  logic              cs_q, busy_q, done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] tx_data;
  logic [FW-1:0]     frame;
  logic              sg_en, sg_tgl, tc, rise, fall, sclk_i;

  // Data phase carries zeros on a read.
  assign tx_data = (rw == RW_WRITE) ? wdata : '0;
  assign frame   = {addr, rw, tx_data};
  assign sg_en   = (state != IDLE);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (sg_en),
    .tgl   (sg_tgl),
    .tc    (tc),
    .rise  (rise),
    .fall  (fall),
    .sclk  (sclk_i)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and sclk toggle enable; the final low phase must not rise again.
  always_comb begin
    state_next = state;
    sg_tgl     = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SETUP;
      SETUP: begin
        sg_tgl = 1'b1;
        if (tc) state_next = SHIFT;
      end
      SHIFT: begin
        sg_tgl = sclk_i || (bc != '0);
        if (tc && !sclk_i && (bc == '0)) state_next = HOLD;
      end
      HOLD:  if (tc) state_next = GAP;
      GAP:   if (tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame latch, bit shifting, miso capture, chip select and handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bc      <= '0;
      rw_q    <= 1'b0;
      rx      <= '0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr     <= frame;
            rw_q   <= rw;
            bc     <= BC_TOP;
            cs_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (fall) sr <= {sr[FW-2:0], 1'b0};
          // bc still names the previous bit here, so bc<=DATA_W marks data bits.
          if (rise) begin
            bc <= bc - 1'b1;
            if ((rw_q == RW_READ) && (bc <= BC_DATA)) rx <= {rx[DATA_W-2:0], miso};
          end
        end
        HOLD: if (tc) cs_q <= 1'b1;
        GAP: begin
          if (tc) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (rw_q == RW_READ) rdata_q <= rx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign sclk  = sclk_i;
  assign cs    = cs_q;
  assign mosi  = sr[FW-1];

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: a CLK_DIV=4 and a CLK_DIV=1 instance, each with a
// behavioural mode-0 SPI memory slave, and a scoreboard of expected frames/rdata.
module tb_spi_mem_master;

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start [2];
  logic       rw    [2];
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] rdata [2];
  logic       sclk  [2];
  logic       cs    [2];
  logic       mosi  [2];
  logic       miso  [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_mem_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start(start[0]), .rw(rw[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_mem_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .rw(rw[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  // Behavioural SPI memory slaves, sampled away from the clock edge.
  logic [7:0]  smem [2][128];
  logic        s_cs_p [2];
  logic        s_sclk_p [2];
  logic        s_rw [2];
  logic [6:0]  s_addr [2];
  logic [15:0] s_sh [2];
  logic [15:0] s_frame [2];
  int          s_rc [2];
  int          s_frames [2] = '{0, 0};
  int          s_gap [2];
  int          s_gap_last [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        s_rc[k]     <= 0;
        miso[k]     <= 1'b0;
        s_cs_p[k]   <= 1'b1;
        s_sclk_p[k] <= 1'b0;
        s_gap[k]    <= 0;
      end else begin
        s_cs_p[k]   <= cs[k];
        s_sclk_p[k] <= sclk[k];
        if (!cs[k] && sclk[k] && !s_sclk_p[k]) begin
          s_sh[k] <= {s_sh[k][14:0], mosi[k]};
          s_rc[k] <= s_rc[k] + 1;
          if (s_rc[k] == 7) begin
            s_addr[k] <= s_sh[k][6:0];
            s_rw[k]   <= mosi[k];
          end
        end
        if (!cs[k] && !sclk[k] && s_sclk_p[k] && (s_rc[k] >= 8) && (s_rc[k] <= 15) && s_rw[k])
          miso[k] <= smem[k][s_addr[k]][3'(15 - s_rc[k])];
        if (cs[k] && !s_cs_p[k]) begin
          if (s_rc[k] == 16) begin
            s_frame[k]  <= s_sh[k];
            s_frames[k] <= s_frames[k] + 1;
            if (!s_sh[k][8]) smem[k][s_sh[k][15:9]] <= s_sh[k][7:0];
          end
          s_rc[k] <= 0;
          miso[k] <= 1'b0;
        end
        if (cs[k]) s_gap[k] <= s_gap[k] + 1;
        if (!cs[k] && s_cs_p[k]) begin
          s_gap_last[k] <= s_gap[k];
          s_gap[k]      <= 0;
        end
      end
    end
  end

  int         n_pass = 0;
  int         n_total = 0;
  sb_t        q0[$];
  sb_t        q1[$];
  logic [7:0] exp_mem [2][128];
  logic [7:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  task automatic push_exp(input int k, input logic r, input logic [6:0] a, input logic [7:0] d);
    sb_t e;
    e.frame = {a, r, (r ? 8'h00 : d)};
    if (r) exp_rd[k] = exp_mem[k][a];
    else exp_mem[k][a] = d;
    e.rdata = exp_rd[k];
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Drive a request for one cycle (or keep start high), then scramble the
  // request fields so only the latched copy can reach the wire.
  task automatic issue(input int k, input logic r, input logic [6:0] a, input logic [7:0] d,
                       input bit keep, output int t0);
    start[k] = 1'b1;
    rw[k]    = r;
    addr[k]  = a;
    wdata[k] = d;
    push_exp(k, r, a, d);
    t0 = cyc;
    @(posedge clk); #1;
    if (!keep) start[k] = 1'b0;
    rw[k]    = ~r;
    addr[k]  = ~a;
    wdata[k] = ~d;
    chk("accept_cs", cs[k], 1'b0);
    chk("accept_busy", busy[k], 1'b1);
    chk("accept_mosi", mosi[k], a[6]);
    chk("accept_sclk", sclk[k], 1'b0);
  endtask

  task automatic wait_done(input int k, input int t0, input int lat);
    sb_t e;
    bit  seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (done[k]) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      chk("latency", cyc - t0, lat);
      chk("done_busy", busy[k], 1'b0);
      chk("done_cs", cs[k], 1'b1);
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        n_total++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("rdata", rdata[k], e.rdata);
        chk("frame", s_frame[k], e.frame);
        $display("txn inst=%0d frame=%h rdata=%h latency=%0d", k, s_frame[k], rdata[k], cyc - t0);
      end
    end
  endtask

  task automatic chk_reset_outputs(input int k, input string tag);
    chk({tag, "_cs"}, cs[k], 1'b1);
    chk({tag, "_sclk"}, sclk[k], 1'b0);
    chk({tag, "_mosi"}, mosi[k], 1'b0);
    chk({tag, "_busy"}, busy[k], 1'b0);
    chk({tag, "_done"}, done[k], 1'b0);
    chk({tag, "_rdata"}, rdata[k], 8'h00);
  endtask

  initial begin
    int t0, tb0, fc;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      rw[k]    = 1'b0;
      addr[k]  = '0;
      wdata[k] = '0;
      exp_rd[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 1: reset while idle acts without a clock edge.
    reset = 1'b1;
    #1;
    chk_reset_outputs(0, "rst_idle");
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // 2: write 0x2A <- 0xA5.
    issue(0, 1'b0, 7'h2A, 8'hA5, 1'b0, t0);
    wait_done(0, t0, 141);
    chk("mem_2a", smem[0][7'h2A], 8'hA5);

    // 3: read 0x2A.
    issue(0, 1'b1, 7'h2A, 8'h00, 1'b0, t0);
    wait_done(0, t0, 141);

    // 4a: start pulses while busy are ignored.
    fc = s_frames[0];
    issue(0, 1'b0, 7'h10, 8'h11, 1'b0, t0);
    repeat (20) @(posedge clk);
    #1 start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 7'h20; wdata[0] = 8'h99;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    wait_done(0, t0, 141);
    repeat (12) @(posedge clk);
    #1;
    chk("ignored_cs", cs[0], 1'b1);
    chk("ignored_busy", busy[0], 1'b0);
    chk("ignored_frames", s_frames[0] - fc, 1);

    // 4b: start held through the done cycle starts the next frame at done+1.
    issue(0, 1'b0, 7'h15, 8'h33, 1'b1, t0);
    rw[0] = 1'b1; addr[0] = 7'h15; wdata[0] = 8'h5A;
    push_exp(0, 1'b1, 7'h15, 8'h5A);
    wait_done(0, t0, 141);
    tb0 = cyc;
    @(posedge clk); #1 start[0] = 1'b0;
    chk("b2b_cs", cs[0], 1'b0);
    chk("b2b_busy", busy[0], 1'b1);
    wait_done(0, tb0, 141);
    chk("cs_gap_min", (s_gap_last[0] >= 4), 1'b1);

    // 5: reset during SHIFT at bit 5, then a clean write/read of 0x01.
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 7'h2A; wdata[0] = 8'h77;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (85) @(posedge clk);
    #1;
    chk("pre_rst_rises", s_rc[0], 11);
    chk("pre_rst_sclk", sclk[0], 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_outputs(0, "rst_shift");
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    issue(0, 1'b0, 7'h01, 8'h3C, 1'b0, t0);
    wait_done(0, t0, 141);
    issue(0, 1'b1, 7'h01, 8'h00, 1'b0, t0);
    wait_done(0, t0, 141);
    chk("mem_2a_kept", smem[0][7'h2A], 8'hA5);

    // 6: CLK_DIV=1 write then read 0x7F.
    issue(1, 1'b0, 7'h7F, 8'hFF, 1'b0, t0);
    wait_done(1, t0, 36);
    issue(1, 1'b1, 7'h7F, 8'h00, 1'b0, t0);
    wait_done(1, t0, 36);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
